// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: core access to byte-enabled memory request with stall, extension and fault
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic [2:0]  lat_size;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_wd;

  logic        size_ok;
  logic        aligned;
  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        timeout_hit;

  // Request decode: lane mask, replicated store data and legality
  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b0;
    be_c    = 4'b0000;
    wd_c    = core_wd_i;
    case (core_size_i)
      3'd0, 3'd4: begin
        size_ok = 1'b1;
        aligned = 1'b1;
        be_c    = 4'b0001 << core_addr_i[1:0];
        wd_c    = {4{core_wd_i[7:0]}};
      end
      3'd1, 3'd5: begin
        size_ok = 1'b1;
        aligned = ~core_addr_i[0];
        be_c    = 4'b0011 << {core_addr_i[1], 1'b0};
        wd_c    = {2{core_wd_i[15:0]}};
      end
      3'd2: begin
        size_ok = 1'b1;
        aligned = (core_addr_i[1:0] == 2'b00);
        be_c    = 4'b1111;
      end
      default: ;
    endcase
    legal = size_ok & aligned & ~(core_we_i & core_size_i[2]);
  end

  // Load lane extraction uses the latched offset, not the live core address
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    ld_b = mem_rd_i[7:0];
      2'd1:    ld_b = mem_rd_i[15:8];
      2'd2:    ld_b = mem_rd_i[23:16];
      default: ld_b = mem_rd_i[31:24];
    endcase
    ld_h = lat_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (lat_size)
      3'd0:    ld_data = {{24{ld_b[7]}}, ld_b};
      3'd1:    ld_data = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_data = {24'b0, ld_b};
      3'd5:    ld_data = {16'b0, ld_h};
      default: ld_data = mem_rd_i;
    endcase
    if (lat_we) ld_data = 32'b0;
  end

  assign timeout_hit = (cnt == TMO_LAST);

  always_comb begin
    core_rd_o    = 32'b0;
    core_stall_o = 1'b0;
    core_fault_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'b0;
    mem_addr_o   = 32'b0;
    mem_wd_o     = 32'b0;
    // Gate on reset so a held core request cannot leak through while in reset
    if (rst_ni) begin
      case (state)
        S_IDLE: begin
          if (core_req_i) begin
            if (legal) begin
              mem_req_o    = 1'b1;
              mem_we_o     = core_we_i;
              mem_be_o     = be_c;
              mem_addr_o   = core_addr_i;
              mem_wd_o     = wd_c;
              core_stall_o = 1'b1;
            end else begin
              core_fault_o = 1'b1;
            end
          end
        end
        default: begin
          mem_req_o  = 1'b1;
          mem_we_o   = lat_we;
          mem_be_o   = lat_be;
          mem_addr_o = lat_addr;
          mem_wd_o   = lat_wd;
          if (mem_ready_i) begin
            core_rd_o = ld_data;
          end else if (timeout_hit) begin
            core_fault_o = 1'b1;
          end else begin
            core_stall_o = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      cnt      <= 8'b0;
      lat_addr <= 32'b0;
      lat_size <= 3'b0;
      lat_we   <= 1'b0;
      lat_be   <= 4'b0;
      lat_wd   <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_req_i && legal) begin
            state    <= S_WAIT;
            cnt      <= 8'b0;
            lat_addr <= core_addr_i;
            lat_size <= core_size_i;
            lat_we   <= core_we_i;
            lat_be   <= be_c;
            lat_wd   <= wd_c;
          end
        end
        default: begin
          cnt <= cnt + 8'd1;
          if (mem_ready_i || timeout_hit) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_checks = 0;
  int n_fails  = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .core_fault_o (core_fault_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd);
    core_req_i  = req;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
  endtask

  // Called just after a rising edge; memory answers in the first WAIT cycle
  task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    set_core(1'b1, we, size, addr, wd);
    mem_ready_i = 1'b1;
    mem_rd_i    = rdata;
    @(negedge clk_i);
    check_val({tag, ".req"},   32'(mem_req_o), 32'd1);
    check_val({tag, ".we"},    32'(mem_we_o), 32'(we));
    check_val({tag, ".be"},    32'(mem_be_o), 32'(exp_be));
    check_val({tag, ".addr"},  mem_addr_o, addr);
    check_val({tag, ".wd"},    mem_wd_o, exp_wd);
    check_val({tag, ".stall"}, 32'(core_stall_o), 32'd1);
    next_cyc();
    core_req_i = 1'b0;
    @(negedge clk_i);
    check_val({tag, ".rsp_stall"}, 32'(core_stall_o), 32'd0);
    check_val({tag, ".rsp_req"},   32'(mem_req_o), 32'd1);
    check_val({tag, ".rsp_fault"}, 32'(core_fault_o), 32'd0);
    check_val({tag, ".rd"},        core_rd_o, exp_rd);
    next_cyc();
  endtask

  task automatic do_illegal(input string tag, input logic we, input logic [2:0] size,
                            input logic [31:0] addr);
    set_core(1'b1, we, size, addr, 32'h1234_5678);
    @(negedge clk_i);
    check_val({tag, ".req"},   32'(mem_req_o), 32'd0);
    check_val({tag, ".stall"}, 32'(core_stall_o), 32'd0);
    check_val({tag, ".fault"}, 32'(core_fault_o), 32'd1);
    next_cyc();
    core_req_i = 1'b0;
    @(negedge clk_i);
    check_val({tag, ".fault_gone"}, 32'(core_fault_o), 32'd0);
    check_val({tag, ".idle_req"},   32'(mem_req_o), 32'd0);
    next_cyc();
  endtask

  initial begin
    rst_ni      = 1'b0;
    set_core(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;
    #12;
    check_val("rst.req",   32'(mem_req_o), 32'd0);
    check_val("rst.stall", 32'(core_stall_o), 32'd0);
    check_val("rst.fault", 32'(core_fault_o), 32'd0);
    check_val("rst.rd",    core_rd_o, 32'd0);
    rst_ni = 1'b1;
    next_cyc();

    do_access("sw",  1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h0);
    do_access("lw",  1'b0, 3'd2, 32'h10, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF);
    do_access("sb",  1'b1, 3'd0, 32'h13, 32'h0000_00A5, 32'h0,         4'b1000, 32'hA5A5_A5A5, 32'h0);
    do_access("lb",  1'b0, 3'd0, 32'h13, 32'h0,         32'h8000_0000, 4'b1000, 32'h0,         32'hFFFF_FF80);
    do_access("lbu", 1'b0, 3'd4, 32'h13, 32'h0,         32'h8000_0000, 4'b1000, 32'h0,         32'h0000_0080);
    do_access("lh",  1'b0, 3'd1, 32'h12, 32'h0,         32'h8001_1234, 4'b1100, 32'h0,         32'hFFFF_8001);
    do_access("lhu", 1'b0, 3'd5, 32'h12, 32'h0,         32'h8001_1234, 4'b1100, 32'h0,         32'h0000_8001);
    do_access("sh",  1'b1, 3'd1, 32'h02, 32'h1111_BEEF, 32'h0,         4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_access("lb1", 1'b0, 3'd0, 32'h01, 32'h0,         32'h0000_7F00, 4'b0010, 32'h0,         32'h0000_007F);

    do_illegal("lw_mis",  1'b0, 3'd2, 32'h11);
    do_illegal("size3",   1'b0, 3'd3, 32'h10);
    do_illegal("sbu",     1'b1, 3'd4, 32'h10);
    do_illegal("lh_mis",  1'b0, 3'd1, 32'h13);

    // Three not-ready WAIT cycles, ready on the 4th which coincides with the timeout
    set_core(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h1234_5678;
    @(negedge clk_i);
    check_val("ws.stall0", 32'(core_stall_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      core_addr_i = 32'h99;
      @(negedge clk_i);
      check_val("ws.stall", 32'(core_stall_o), 32'd1);
      check_val("ws.addr",  mem_addr_o, 32'h20);
      check_val("ws.be",    32'(mem_be_o), 32'hF);
      check_val("ws.fault", 32'(core_fault_o), 32'd0);
    end
    next_cyc();
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    check_val("ws.rsp_stall", 32'(core_stall_o), 32'd0);
    check_val("ws.rsp_fault", 32'(core_fault_o), 32'd0);
    check_val("ws.rd",        core_rd_o, 32'h1234_5678);
    next_cyc();
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
    next_cyc();

    // Timeout: ready never comes
    set_core(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
    mem_rd_i = 32'hFFFF_FFFF;
    for (int i = 1; i <= 3; i++) begin
      next_cyc();
      @(negedge clk_i);
      check_val("to.stall", 32'(core_stall_o), 32'd1);
      check_val("to.fault", 32'(core_fault_o), 32'd0);
    end
    next_cyc();
    @(negedge clk_i);
    check_val("to.fault4", 32'(core_fault_o), 32'd1);
    check_val("to.stall4", 32'(core_stall_o), 32'd0);
    check_val("to.rd4",    core_rd_o, 32'h0);
    next_cyc();
    core_req_i = 1'b0;
    @(negedge clk_i);
    check_val("to.idle_req",   32'(mem_req_o), 32'd0);
    check_val("to.idle_fault", 32'(core_fault_o), 32'd0);
    next_cyc();

    // Reset pulled asynchronously in the 2nd WAIT cycle
    set_core(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
    next_cyc();
    next_cyc();
    check_val("rw.req_before", 32'(mem_req_o), 32'd1);
    #1;
    rst_ni     = 1'b0;
    core_req_i = 1'b0;
    #1;
    check_val("rw.req_async",   32'(mem_req_o), 32'd0);
    check_val("rw.stall_async", 32'(core_stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    next_cyc();
    @(negedge clk_i);
    check_val("rw.idle_req", 32'(mem_req_o), 32'd0);
    next_cyc();
    do_access("rw_lw", 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
